// File: rtl/mac_dot_unit.sv
// mac_dot_unit
//   Signed multiply-accumulate engine. Computes the dot product of i_len
//   operand pairs streamed over a valid/ready interface, framed by a
//   four-phase start/ack job handshake. Optional ReLU on the result and a
//   sticky overflow flag per job.
//
//   Build option: MAC_DOT_SATURATE_EN
//     defined   - accumulator clamps to the signed ACC_WIDTH limits on overflow
//     undefined - accumulator wraps modulo 2^ACC_WIDTH on overflow
//
//   Ports
//     i_clk, i_rst_n            clock (rising edge), async active-low reset
//     i_start, i_len, i_relu    job request (level) with its length / ReLU flag
//     o_ack                     job accepted, held while i_start stays high
//     i_a, i_b, i_in_valid      signed operand pair and its valid
//     o_in_ready                engine takes a/b this cycle (registered)
//     o_acc_out, o_done, o_ovf  result, one-cycle done pulse, sticky overflow
//     o_busy                    engine is not idle
//
//   state  | meaning
//   IDLE   | waiting for a new start (start must have dropped since last job)
//   ACCUM  | accepting operand pairs, in_ready high
//   DRAIN  | last pair taken, waiting for the product pipeline to empty
module mac_dot_unit #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int LEN_WIDTH = 10
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic        [LEN_WIDTH-1:0] i_len,
  input  logic                        i_relu,
  output logic                        o_ack,
  input  logic signed [WIDTH-1:0]     i_a,
  input  logic signed [WIDTH-1:0]     i_b,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  output logic signed [ACC_WIDTH-1:0] o_acc_out,
  output logic                        o_done,
  output logic                        o_busy,
  output logic                        o_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                        r_state, w_state_nxt;
  logic                          r_ack, w_ack_nxt;
  logic                          r_in_ready, w_in_ready_nxt;
  logic                          r_done, w_done_nxt;
  logic                          r_busy, w_busy_nxt;
  logic                          r_ovf, w_ovf_nxt;
  logic                          r_relu, w_relu_nxt;
  logic                          r_prod_vld, w_prod_vld_nxt;
  logic                          r_drain_settle, w_drain_settle_nxt;
  logic        [LEN_WIDTH-1:0]   r_remain, w_remain_nxt;
  logic signed [2*WIDTH-1:0]     r_prod, w_prod_nxt;
  logic signed [ACC_WIDTH-1:0]   r_acc, w_acc_nxt;
  logic signed [ACC_WIDTH-1:0]   r_acc_out, w_acc_out_nxt;

  logic                          w_xfer;
  logic                          w_accept;
  logic signed [2*WIDTH-1:0]     w_prod;
  logic signed [ACC_WIDTH:0]     w_sum;
  logic                          w_sum_ovf;

  assign w_xfer   = (r_state == S_ACCUM) && i_in_valid && r_in_ready;
  assign w_accept = (r_state == S_IDLE) && i_start && !r_ack;
  assign w_prod   = (2*WIDTH)'(i_a) * (2*WIDTH)'(i_b);

  // One guard bit above the accumulator: the top two bits differ exactly
  // when the ACC_WIDTH-bit signed add overflowed.
  assign w_sum     = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(r_prod);
  assign w_sum_ovf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

  always_comb begin
    w_state_nxt        = r_state;
    w_ack_nxt          = i_start ? r_ack : 1'b0;
    w_in_ready_nxt     = r_in_ready;
    w_done_nxt         = 1'b0;
    w_busy_nxt         = r_busy;
    w_ovf_nxt          = r_ovf;
    w_relu_nxt         = r_relu;
    w_prod_vld_nxt     = w_xfer;
    w_prod_nxt         = w_xfer ? w_prod : r_prod;
    w_drain_settle_nxt = 1'b0;
    w_remain_nxt       = r_remain;
    w_acc_nxt          = r_acc;
    w_acc_out_nxt      = r_acc_out;

    if (r_prod_vld) begin
      w_acc_nxt = w_sum[ACC_WIDTH-1:0];
      if (w_sum_ovf) begin
        w_ovf_nxt = 1'b1;
`ifdef MAC_DOT_SATURATE_EN
        // Sign of the true sum is the guard bit.
        w_acc_nxt = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
`endif
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_remain_nxt = i_len;
          w_relu_nxt   = i_relu;
          w_acc_nxt    = '0;
          w_ovf_nxt    = 1'b0;
          w_ack_nxt    = 1'b1;
          w_busy_nxt   = 1'b1;
          if (i_len != '0) begin
            w_in_ready_nxt = 1'b1;
            w_state_nxt    = S_ACCUM;
          end else begin
            w_drain_settle_nxt = 1'b1;
            w_state_nxt        = S_DRAIN;
          end
        end
      end
      S_ACCUM: begin
        if (w_xfer) begin
          w_remain_nxt = r_remain - LEN_WIDTH'(1);
          if (r_remain == LEN_WIDTH'(1)) begin
            w_in_ready_nxt     = 1'b0;
            w_drain_settle_nxt = 1'b1;
            w_state_nxt        = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Spend at least one cycle in DRAIN so that an empty job has the
        // same two-edge done latency as the pipeline tail of a real job.
        if (!r_prod_vld && !r_drain_settle) begin
          w_acc_out_nxt = (r_relu && r_acc[ACC_WIDTH-1]) ? '0 : r_acc;
          w_done_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_ack          <= 1'b0;
      r_in_ready     <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
      r_ovf          <= 1'b0;
      r_relu         <= 1'b0;
      r_prod_vld     <= 1'b0;
      r_drain_settle <= 1'b0;
      r_remain       <= '0;
      r_prod         <= '0;
      r_acc          <= '0;
      r_acc_out      <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_ack          <= w_ack_nxt;
      r_in_ready     <= w_in_ready_nxt;
      r_done         <= w_done_nxt;
      r_busy         <= w_busy_nxt;
      r_ovf          <= w_ovf_nxt;
      r_relu         <= w_relu_nxt;
      r_prod_vld     <= w_prod_vld_nxt;
      r_drain_settle <= w_drain_settle_nxt;
      r_remain       <= w_remain_nxt;
      r_prod         <= w_prod_nxt;
      r_acc          <= w_acc_nxt;
      r_acc_out      <= w_acc_out_nxt;
    end
  end

  assign o_ack      = r_ack;
  assign o_in_ready = r_in_ready;
  assign o_done     = r_done;
  assign o_busy     = r_busy;
  assign o_ovf      = r_ovf;
  assign o_acc_out  = r_acc_out;

endmodule

// File: tb/tb_mac_dot_unit.sv
// Bench for mac_dot_unit, built with a 16-bit accumulator so that overflow
// is reachable with 8-bit operands. Honours MAC_DOT_SATURATE_EN.
module tb_mac_dot_unit;
  localparam int W  = 8;
  localparam int AW = 16;
  localparam int LW = 10;
  localparam longint AMAX = 32767;
  localparam longint AMIN = -32768;
  localparam longint AMOD = 65536;
`ifdef MAC_DOT_SATURATE_EN
  localparam int OVF_RES = 32767;
`else
  localparam int OVF_RES = -16384;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 relu = 1'b0;
  logic                 in_valid = 1'b0;
  logic [LW-1:0]        len = '0;
  logic signed [W-1:0]  a = '0;
  logic signed [W-1:0]  b = '0;
  logic                 ack, in_ready, done, busy, ovf;
  logic signed [AW-1:0] acc_out;

  mac_dot_unit #(.WIDTH(W), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .i_relu(relu),
    .o_ack(ack), .i_a(a), .i_b(b), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_acc_out(acc_out), .o_done(done), .o_busy(busy), .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer dot product, range-checked after every term.
  function automatic void model(input int n, input bit rl, input int av[16],
                                input int bv[16], output int res, output bit ov);
    longint acc = 0;
    ov = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc += longint'(av[i]) * longint'(bv[i]);
      if (acc > AMAX || acc < AMIN) begin
        ov = 1'b1;
`ifdef MAC_DOT_SATURATE_EN
        acc = (acc > AMAX) ? AMAX : AMIN;
`else
        acc = (((acc - AMIN) % AMOD) + AMOD) % AMOD + AMIN;
`endif
      end
    end
    res = (rl && acc < 0) ? 0 : int'(acc);
  endfunction

  // Edges are counted from the edge that samples start (edge 0).
  // vmode: 0 = valid always, 1 = valid pattern 1,0,0, 2 = random valid.
  task automatic run_job(input int n, input bit rl, input int vmode, input bit hold,
                         input int av[16], input int bv[16],
                         output int done_e, output int last_e, output int nx,
                         output int res, output bit ov);
    int idx = 0;
    int ecnt = 0;
    bit pv, pr;
    done_e = -1; last_e = 0; res = 0; ov = 1'b0;
    start = 1'b1; len = LW'(n); relu = rl; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ack_after_start", longint'(ack), 1);
    chk("busy_after_start", longint'(busy), 1);
    if (!hold) start = 1'b0;
    for (int cyc = 0; cyc < 300 && done_e < 0; cyc++) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 3 == 0);
        default: in_valid = 1'($urandom_range(1));
      endcase
      a = (idx < n) ? W'(av[idx]) : W'($urandom);
      b = (idx < n) ? W'(bv[idx]) : W'($urandom);
      pv = in_valid; pr = in_ready;
      @(posedge clk); #1;
      ecnt++;
      if (pv && pr) begin
        idx++;
        last_e = ecnt;
        if (idx == n) chk("in_ready_drop", longint'(in_ready), 0);
      end
      if (done) begin
        done_e = ecnt;
        res    = int'(acc_out);
        ov     = ovf;
      end
    end
    in_valid = 1'b0;
    nx = idx;
    if (done_e < 0) chk("done_timeout", 0, 1);
    else begin
      @(posedge clk); #1;
      chk("done_one_cycle", longint'(done), 0);
      chk("busy_after_done", longint'(busy), 0);
    end
  endtask

  typedef struct {
    int n; bit rl; int vm;
    int av[4]; int bv[4];
    int exp_res; bit exp_ov; int exp_de;
  } vec_t;

  vec_t vt[5];

  function automatic void set_vec(input int i, input int n, input bit rl, input int vm,
                                  input int a0, input int a1, input int a2, input int a3,
                                  input int b0, input int b1, input int b2, input int b3,
                                  input int er, input bit eo, input int ed);
    vt[i].n = n; vt[i].rl = rl; vt[i].vm = vm;
    vt[i].av[0] = a0; vt[i].av[1] = a1; vt[i].av[2] = a2; vt[i].av[3] = a3;
    vt[i].bv[0] = b0; vt[i].bv[1] = b1; vt[i].bv[2] = b2; vt[i].bv[3] = b3;
    vt[i].exp_res = er; vt[i].exp_ov = eo; vt[i].exp_de = ed;
  endfunction

  initial begin
    int av[16], bv[16];
    int de, le, nx, res, mres, ndone;
    bit ov, mov;

    set_vec(0, 3, 0, 0,    2,   -3,    4, 0,    5,    6,   -7, 0, -36,     0,  5);
    set_vec(1, 3, 1, 0,    2,   -3,    4, 0,    5,    6,   -7, 0,   0,     0,  5);
    set_vec(2, 3, 1, 0,    2,   -3,    4, 0,    5,   -6,    7, 0,  56,     0,  5);
    set_vec(3, 4, 0, 1,    1,    2,    3, 4,    1,    2,    3, 4,  30,     0, 12);
    set_vec(4, 3, 0, 0, -128, -128, -128, 0, -128, -128, -128, 0, OVF_RES, 1,  5);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", longint'(ack), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_acc_out", longint'(acc_out), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      foreach (av[k]) begin av[k] = 0; bv[k] = 0; end
      for (int k = 0; k < 4; k++) begin av[k] = vt[i].av[k]; bv[k] = vt[i].bv[k]; end
      run_job(vt[i].n, vt[i].rl, vt[i].vm, 1'b0, av, bv, de, le, nx, res, ov);
      chk($sformatf("vec%0d_result", i), longint'(res), longint'(vt[i].exp_res));
      chk($sformatf("vec%0d_ovf", i), longint'(ov), longint'(vt[i].exp_ov));
      chk($sformatf("vec%0d_done_edge", i), longint'(de), longint'(vt[i].exp_de));
      chk($sformatf("vec%0d_xfers", i), longint'(nx), longint'(vt[i].n));
      chk($sformatf("vec%0d_done_after_last", i), longint'(de), longint'(le + 2));
      chk($sformatf("vec%0d_ack_released", i), longint'(ack), 0);
    end

    // Zero length with start held: no retrigger until start drops.
    run_job(0, 1'b0, 0, 1'b1, av, bv, de, le, nx, res, ov);
    chk("zero_len_done_edge", longint'(de), 2);
    chk("zero_len_result", longint'(res), 0);
    ndone = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("held_start_no_retrigger", longint'(ndone), 0);
    chk("held_start_ack_high", longint'(ack), 1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("ack_falls_after_start_drop", longint'(ack), 0);
    for (int k = 0; k < 4; k++) begin av[k] = vt[0].av[k]; bv[k] = vt[0].bv[k]; end
    run_job(3, 1'b0, 0, 1'b0, av, bv, de, le, nx, res, ov);
    chk("rearm_result", longint'(res), -36);

    // Reset in the middle of an 8-term job.
    start = 1'b1; len = LW'(8); relu = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; a = 8'sd3; b = 8'sd3;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_zero_outputs",
        longint'({ack, in_ready, done, busy, ovf, (acc_out != 0)}), 0);
    in_valid = 1'b0;
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (done) ndone++;
    chk("midrst_no_done", longint'(ndone), 0);
    for (int k = 0; k < 5; k++) begin av[k] = k + 1; bv[k] = 10 - k; end
    model(5, 1'b0, av, bv, mres, mov);
    run_job(5, 1'b0, 0, 1'b0, av, bv, de, le, nx, res, ov);
    chk("post_rst_result", longint'(res), longint'(mres));
    chk("post_rst_ovf", longint'(ov), longint'(mov));

    // Random jobs against the reference model.
    for (int j = 0; j < 14; j++) begin
      int n;
      bit rl;
      n  = int'($urandom_range(12));
      rl = 1'($urandom_range(1));
      foreach (av[k]) begin
        av[k] = int'($urandom_range(255)) - 128;
        bv[k] = int'($urandom_range(255)) - 128;
      end
      model(n, rl, av, bv, mres, mov);
      run_job(n, rl, 2, 1'b0, av, bv, de, le, nx, res, ov);
      chk($sformatf("rnd%0d_result", j), longint'(res), longint'(mres));
      chk($sformatf("rnd%0d_ovf", j), longint'(ov), longint'(mov));
      chk($sformatf("rnd%0d_xfers", j), longint'(nx), longint'(n));
      chk($sformatf("rnd%0d_done_edge", j), longint'(de), longint'((n == 0) ? 2 : le + 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_dot_unit.md
Name: mac_dot_unit

Overview:
- Parametrised signed multiply-accumulate engine for the inference datapath; successor to the single-shot multiplier.
- Computes a dot product of LEN operand pairs streamed over a valid/ready interface.
- Keeps the four-phase start/ack/done job handshake, with optional ReLU on the result and sticky overflow reporting.
- Sits between weight/pixel fetch and the neuron activation buffer.

Parameters:
- WIDTH, 8: signed width of operands a and b.
- ACC_WIDTH, 24: signed accumulator/result width; must be >= 2*WIDTH.
- LEN_WIDTH, 10: width of the job length field; max job length is 2^LEN_WIDTH-1 terms.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job request, level, four-phase.
- len  in  LEN_WIDTH  number of operand pairs; sampled with start.
- relu  in  1  apply ReLU to the result; sampled with start.
- ack  out  1  job accepted; held while start is high.
- a  in  WIDTH  signed operand.
- b  in  WIDTH  signed operand.
- in_valid  in  1  a/b valid.
- in_ready  out  1  engine accepts a/b this cycle (registered).
- acc_out  out  ACC_WIDTH  signed result; held until the next done.
- done  out  1  one-cycle pulse; acc_out/ovf valid.
- busy  out  1  high in any state other than IDLE.
- ovf  out  1  sticky accumulator overflow for the current job.

Behaviour:
- Reset (async, rst_n=0): state IDLE; ack, in_ready, done, busy, ovf, acc_out, accumulator, product register, product-valid and remaining counter all 0. Reset mid-job aborts silently; no done is issued.
- States: IDLE, ACCUM, DRAIN.
- IDLE, job acceptance: a job is accepted when start=1 and ack=0.
  - Latch len into the remaining counter and latch relu.
  - Clear the accumulator and ovf.
  - Set ack<=1 and busy<=1.
  - If len!=0: in_ready<=1, go to ACCUM.
  - If len==0: go to DRAIN.
- ack release: ack<=0 on any edge where start is sampled 0, in any state. A held start never retriggers a job; start must drop between jobs.
- ACCUM:
  - Transfer occurs on in_valid & in_ready.
  - On transfer: product register <= a*b (signed, 2*WIDTH bits), product-valid<=1, remaining--.
  - When the transfer consumes the last pair: in_ready<=0 on the same edge, go to DRAIN.
  - in_valid gaps stall without penalty; a/b are ignored when in_ready=0.
- Accumulate stage:
  - Every cycle product-valid=1: acc <= acc + sign-extended product.
  - product-valid clears when no transfer occurs.
- DRAIN: when product-valid=0 then:
  - acc_out <= (latched relu && acc<0) ? 0 : acc.
  - done<=1 for one cycle.
  - busy<=0, go to IDLE.
- Latency: with in_valid held high, pair k is accepted at edge k+1 after the start edge; done is asserted at edge len+2. For len==0, done is asserted at edge 2.
- Overflow: ovf<=1 when a signed add overflows ACC_WIDTH; it stays set until the next job start. Overflow handling is selected by the macro below.
- done and ack are independent; done may pulse while ack is still high.

Optional Feature:
- Macro: MAC_DOT_SATURATE_EN.
- Defined: on overflow the accumulator clamps to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1) and stays clamped until a term moves it back in range; ovf is set.
- Undefined: the accumulator wraps modulo 2^ACC_WIDTH; ovf is still set.

Test Plan:
- Basic dot product: len=3, relu=0, a={2,-3,4}, b={5,6,-7}, in_valid continuous -> ack high the cycle after start; done at edge 5; acc_out=-36; ovf=0.
- ReLU: same stimulus with relu=1 -> acc_out=0. Rerun with b={5,-6,7} -> acc_out=56.
- Stalls: len=4, a=b={1,2,3,4}, in_valid toggling 1,0,0,1,... -> exactly 4 transfers; in_ready drops after the 4th; acc_out=30; done only after the last transfer plus 2 edges.
- Overflow: WIDTH=8, ACC_WIDTH=16, len=3, a=b=-128 -> ovf=1; acc_out=-16384 without the macro, 32767 with MAC_DOT_SATURATE_EN.
- Zero length and no retrigger: len=0 -> done at edge 2 with acc_out=0. Hold start high afterwards -> no second done. Drop start -> ack falls next edge. Raise start again -> new job accepted.
- Reset mid-job: len=8, assert rst_n=0 after 3 transfers -> all outputs 0 immediately and no done. A new job after release computes a correct, uncorrupted result.
